hazard_fwd_ctrl: RTL and testbench

- Producer-side counterpart of the D-stage forwarding muxes in the 5-stage MIPS pipeline.
- Tracks the destination register and remaining latency (Tnew) of every in-flight instruction in E, M and W.
- Generates the 2-bit select codes consumed by the D-stage RD1/RD2 forwarding muxes (2 = M, 1 = W, 0 = register file) and the D-stage stall.
- Owns the multiply/divide busy counter that stalls HI/LO consumers.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 20 ++
 rtl/hazard_fwd_ctrl_if.sv | 30 +++
 rtl/hazard_fwd_ctrl_fwd_sel_unit.sv | 42 ++++
 rtl/hazard_fwd_ctrl.sv | 74 +++++++
 tb/tb_hazard_fwd_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings and defaults for the D-stage hazard / forwarding controller.
package hazard_fwd_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    localparam logic [1:0] TUSE_UNUSED = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Tnew counts down by one per stage and parks at zero once the result exists.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// D-stage operand/producer info in, forwarding selects / stall / md_busy out.
interface hazard_fwd_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] D_rs;
    logic [REG_AW-1:0] D_rt;
    logic [1:0]        D_Tuse_rs;
    logic [1:0]        D_Tuse_rt;
    logic [REG_AW-1:0] D_dst;
    logic [1:0]        D_Tnew;
    logic              D_is_md;
    logic              E_md_start;
    logic              E_md_div;
    logic [1:0]        D_ForwardRD1Mux_Sel;
    logic [1:0]        D_ForwardRD2Mux_Sel;
    logic              D_stall;
    logic              md_busy;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_dst, D_Tnew, D_is_md,
               E_md_start, E_md_div,
        input  D_ForwardRD1Mux_Sel, D_ForwardRD2Mux_Sel, D_stall, md_busy
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_dst, D_Tnew, D_is_md,
               E_md_start, E_md_div,
        output D_ForwardRD1Mux_Sel, D_ForwardRD2Mux_Sel, D_stall, md_busy
    );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// Per-source forward select and stall term, from one D operand and the E/M/W tags.
module fwd_sel_unit
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [1:0]        tuse,
    input  logic [REG_AW-1:0] e_addr,
    input  logic [1:0]        e_tnew,
    input  logic [REG_AW-1:0] m_addr,
    input  logic [1:0]        m_tnew,
    input  logic [REG_AW-1:0] w_addr,
    output logic [1:0]        sel,
    output logic              stall
);
    logic [1:0] eff_e_tnew;
    logic       src_live;

    // Nothing forwards from E into D, so even a Tnew=0 producer in E costs a cycle.
    assign eff_e_tnew = (e_tnew == 2'd0) ? 2'd1 : e_tnew;
    assign src_live   = (src != '0);

    always_comb begin
        stall = 1'b0;
        if (src_live && (tuse != TUSE_UNUSED)) begin
            stall = ((src == e_addr) && (tuse < eff_e_tnew)) ||
                    ((src == m_addr) && (tuse < m_tnew));
        end
    end

    // A not-ready M match deliberately hides an older W copy; the stall covers it.
    always_comb begin
        sel = FWD_RF;
        if (src_live) begin
            if (src == m_addr)
                sel = (m_tnew == 2'd0) ? FWD_M : FWD_RF;
            else if (src == w_addr)
                sel = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Producer tag pipeline (E/M/W), D-stage forward selects and stall, mult/div busy counter.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_ctrl_if.slave  bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [REG_AW-1:0] e_addr, m_addr, w_addr;
    logic [1:0]        e_tnew, m_tnew;
    logic [CNT_W-1:0]  md_cnt, md_cnt_next;
    logic              md_busy_q;
    logic              stall_rs, stall_rt, stall_md, stall;

    fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_rs (
        .src(bus.D_rs), .tuse(bus.D_Tuse_rs),
        .e_addr(e_addr), .e_tnew(e_tnew), .m_addr(m_addr), .m_tnew(m_tnew),
        .w_addr(w_addr), .sel(bus.D_ForwardRD1Mux_Sel), .stall(stall_rs)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_rt (
        .src(bus.D_rt), .tuse(bus.D_Tuse_rt),
        .e_addr(e_addr), .e_tnew(e_tnew), .m_addr(m_addr), .m_tnew(m_tnew),
        .w_addr(w_addr), .sel(bus.D_ForwardRD2Mux_Sel), .stall(stall_rt)
    );

    assign stall_md    = bus.D_is_md && (md_busy_q || bus.E_md_start);
    assign stall       = stall_rs || stall_rt || stall_md;
    assign bus.D_stall = stall;
    assign bus.md_busy = md_busy_q;

    // W data is always written back before D reads it, so W's Tnew is never consulted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_addr <= '0;
            e_tnew <= 2'd0;
            m_addr <= '0;
            m_tnew <= 2'd0;
            w_addr <= '0;
        end else begin
            e_addr <= stall ? '0 : bus.D_dst;
            e_tnew <= stall ? 2'd0 : bus.D_Tnew;
            m_addr <= e_addr;
            m_tnew <= sat_dec(e_tnew);
            w_addr <= m_addr;
        end
    end

    // A start always reloads, even over a running operation.
    always_comb begin
        md_cnt_next = md_cnt;
        if (bus.E_md_start)
            md_cnt_next = bus.E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt != '0)
            md_cnt_next = md_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt    <= '0;
            md_busy_q <= 1'b0;
        end else begin
            md_cnt    <= md_cnt_next;
            md_busy_q <= (md_cnt_next != '0);
        end
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scenarios for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_fwd_ctrl_if #(.REG_AW(5)) bus ();

    hazard_fwd_ctrl #(.REG_AW(5), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [1:0] tuse_rs,
                         input logic [4:0] rt, input logic [1:0] tuse_rt,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic is_md);
        bus.D_rs = rs;  bus.D_Tuse_rs = tuse_rs;
        bus.D_rt = rt;  bus.D_Tuse_rt = tuse_rt;
        bus.D_dst = dst; bus.D_Tnew = tnew; bus.D_is_md = is_md;
        #1;
    endtask

    task automatic flush();
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
        set_d(5'd8, 2'd0, 5'd9, 2'd0, 5'd8, 2'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd0) begin errors++; $display("FAIL rst_sel1: got %0d expected 0", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd0) begin errors++; $display("FAIL rst_sel2: got %0d expected 0", bus.D_ForwardRD2Mux_Sel); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", bus.md_busy); end
        reset = 1'b1;
        flush();
    endtask

    task automatic test_load_use();
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);    // lw $8
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall: got %0b expected 0", bus.D_stall); end
        cyc();
        set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 2'd1, 1'b0);   // add $10,$8,$9
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL lu_e_stall: got %0b expected 1", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd0) begin errors++; $display("FAIL lu_e_sel1: got %0d expected 0", bus.D_ForwardRD1Mux_Sel); end
        cyc();
        cyc();
        set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd1) begin errors++; $display("FAIL lu_w_sel1: got %0d expected 1", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL lu_w_stall: got %0b expected 0", bus.D_stall); end
    endtask

    task automatic test_load_branch();
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);
        cyc();
        set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);    // beq on $8
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL lb_e_stall: got %0b expected 1", bus.D_stall); end
        cyc();
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL lb_m_stall: got %0b expected 1", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd0) begin errors++; $display("FAIL lb_m_sel1: got %0d expected 0", bus.D_ForwardRD1Mux_Sel); end
        cyc();
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL lb_w_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd1) begin errors++; $display("FAIL lb_w_sel1: got %0d expected 1", bus.D_ForwardRD1Mux_Sel); end
    endtask

    task automatic test_alu_branch();
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0);    // add $9
        cyc();
        set_d(5'd9, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);    // beq $9,$9
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL ab_e_stall: got %0b expected 1", bus.D_stall); end
        cyc();
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL ab_m_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd2) begin errors++; $display("FAIL ab_m_sel1: got %0d expected 2", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd2) begin errors++; $display("FAIL ab_m_sel2: got %0d expected 2", bus.D_ForwardRD2Mux_Sel); end
    endtask

    task automatic test_dual_match();
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0);
        cyc();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0);
        cyc();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        cyc();
        set_d(5'd5, 2'd1, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0);    // $5 in M (ready) and W
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd2) begin errors++; $display("FAIL dm_mw_sel1: got %0d expected 2", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd2) begin errors++; $display("FAIL dm_mw_sel2: got %0d expected 2", bus.D_ForwardRD2Mux_Sel); end
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL dm_mw_stall: got %0b expected 0", bus.D_stall); end
        cyc();
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd1) begin errors++; $display("FAIL dm_w_sel1: got %0d expected 1", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL dm_w_stall: got %0b expected 0", bus.D_stall); end
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0);    // bubble carrying Tnew 2
        cyc();
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL dm_r0_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd0) begin errors++; $display("FAIL dm_r0_sel1: got %0d expected 0", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd0) begin errors++; $display("FAIL dm_r0_sel2: got %0d expected 0", bus.D_ForwardRD2Mux_Sel); end
    endtask

    task automatic test_jal();
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0);   // jal
        cyc();
        set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);   // jr $31
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL jal_e_stall: got %0b expected 1", bus.D_stall); end
        cyc();
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL jal_m_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd2) begin errors++; $display("FAIL jal_m_sel1: got %0d expected 2", bus.D_ForwardRD1Mux_Sel); end
    endtask

    task automatic test_md_busy();
        int n;
        flush();
        bus.E_md_start = 1'b1;
        bus.E_md_div   = 1'b1;
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, 1'b1);    // mflo behind a starting div
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL md_start_stall: got %0b expected 1", bus.D_stall); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL md_start_busy: got %0b expected 0", bus.md_busy); end
        cyc();
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
        #1;
        for (int i = 0; i <= 10; i++) begin
            checks++; if (bus.md_busy !== (i < 10)) begin errors++; $display("FAIL div_busy[%0d]: got %0b expected %0b", i, bus.md_busy, (i < 10)); end
            checks++; if (bus.D_stall !== (i < 10)) begin errors++; $display("FAIL div_stall[%0d]: got %0b expected %0b", i, bus.D_stall, (i < 10)); end
            cyc();
        end
        flush();
        bus.E_md_start = 1'b1;
        cyc();
        bus.E_md_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.md_busy === 1'b1) n++;
            cyc();
        end
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
    endtask

    task automatic test_reset_mid_stall();
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd1, 1'b0);
        cyc();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        cyc();
        bus.E_md_start = 1'b1;
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);    // lw $8 beside a mult start
        cyc();
        bus.E_md_start = 1'b0;
        set_d(5'd8, 2'd1, 5'd7, 2'd1, 5'd10, 2'd1, 1'b0);
        checks++; if (bus.D_stall !== 1'b1) begin errors++; $display("FAIL rm_pre_stall: got %0b expected 1", bus.D_stall); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd1) begin errors++; $display("FAIL rm_pre_sel2: got %0d expected 1", bus.D_ForwardRD2Mux_Sel); end
        checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL rm_pre_busy: got %0b expected 1", bus.md_busy); end
        reset = 1'b0;
        #1;
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL rm_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd0) begin errors++; $display("FAIL rm_sel1: got %0d expected 0", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd0) begin errors++; $display("FAIL rm_sel2: got %0d expected 0", bus.D_ForwardRD2Mux_Sel); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %0b expected 0", bus.md_busy); end
        cyc();
        reset = 1'b1;
        set_d(5'd8, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0);
        checks++; if (bus.D_stall !== 1'b0) begin errors++; $display("FAIL rm_post_stall: got %0b expected 0", bus.D_stall); end
        checks++; if (bus.D_ForwardRD1Mux_Sel !== 2'd0) begin errors++; $display("FAIL rm_post_sel1: got %0d expected 0", bus.D_ForwardRD1Mux_Sel); end
        checks++; if (bus.D_ForwardRD2Mux_Sel !== 2'd0) begin errors++; $display("FAIL rm_post_sel2: got %0d expected 0", bus.D_ForwardRD2Mux_Sel); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_dual_match();
        test_jal();
        test_md_busy();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
